rect_calc_hs: RTL and testbench
===============================

Name: rect_calc_hs

Overview:
- Parametrised successor of the two-producer / one-consumer rectangle unit.
- Collects side lengths A and B from two independent dav_/rfd producers and computes either the area A*B (sequential shift-add) or the perimeter 2*(A+B).
- Delivers the 2W-bit result to one consumer over the same dav_/rfd handshake.
- Sits between the operand producers and the result consumer in the geometry datapath.

Parameters:
- W, 8, operand width in bits; W >= 2; result width is 2*W.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- mode  input  1  0 = area, 1 = perimeter; sampled on the cycle the FSM leaves COLLECT.
- data_in_1  input  W  side A from producer 1.
- dav_in_1_  input  1  producer 1 data valid, active low.
- rfd_in_1  output  1  ready-for-data to producer 1, active high.
- data_in_2  input  W  side B from producer 2.
- dav_in_2_  input  1  producer 2 data valid, active low.
- rfd_in_2  output  1  ready-for-data to producer 2, active high.
- data_out  output  2W  result to consumer.
- dav_out_  output  1  result valid, active low.
- rfd_out  input  1  consumer ready-for-data, active high.

Behaviour:
- Reset values: rfd_in_1=1, rfd_in_2=1, dav_out_=1, data_out=0; state COLLECT; both channel flags cleared; counter 0. Reset overrides any state, including mid-CALC and mid-OUT; partial operands are discarded.
- Each input channel k is tracked independently with flags got_k and done_k, both 0 after reset.
- Capture: in COLLECT with got_k=0, dav_in_k_=0 sampled -> latch data_in_k; got_k<=1; rfd_in_k<=0 on the next edge.
- Release: with got_k=1, dav_in_k_=1 sampled -> done_k<=1.
- rfd_in_k stays 0 from capture until the result handshake completes. A second dav_in_k_ low during this window is ignored.
- Producers may be staggered by any number of cycles; data captured at the same edge on both channels is legal.
- COLLECT -> CALC on the edge where done_1 and done_2 are both 1. mode is latched on this edge, the accumulator is cleared, and counter<=0.
- CALC, area mode: one shift-add step per cycle, LSB-first over the B multiplier, accumulating into a 2W-bit register. Exactly W cycles, then -> WAIT_RFD. The product is exact (no truncation).
- CALC, perimeter mode: result <= zero-extend(A+B) << 1, computed in W+2 bits then zero-extended to 2W. Takes 1 cycle, then -> WAIT_RFD.
- WAIT_RFD: data_out holds the result.
  - rfd_out=1 sampled -> dav_out_<=0, go to HOLD.
  - rfd_out=0 -> wait indefinitely.
- HOLD: dav_out_=0 and data_out stable until rfd_out=0 is sampled. Then dav_out_<=1, rfd_in_1<=1, rfd_in_2<=1, all flags cleared, -> COLLECT.
- Latency, last dav_in_k_ rising edge to dav_out_ low with rfd_out already 1:
  - area: 1 (done flag) + 1 (enter CALC) + W + 1 cycles.
  - perimeter: 4 cycles.
- data_out retains the last result in COLLECT; it is updated only on the CALC -> WAIT_RFD edge.
- Operand values 0 and 2^W-1 are legal. The maximum area (2^W-1)^2 fits in 2W bits.

Optional Feature:
- Macro RECT_CALC_ZERO_SHORT_EN.
- Defined: in area mode, if A==0 or B==0 at CALC entry, result=0 and the FSM goes to WAIT_RFD after 1 CALC cycle instead of W.
- Undefined: area always takes W CALC cycles, regardless of operand values.
- Functional results are identical with or without the macro; only latency differs.

Test Plan:
- W=8, mode=0, A=5, B=6; both dav_ low together, high after both rfd_in fall; rfd_out=1 -> data_out=0x001E, dav_out_ low 11 cycles after dav_ release; rfd_out=0 -> dav_out_=1, rfd_in_1=rfd_in_2=1.
- W=8, mode=1, A=5, B=6 -> data_out=22. Latency 4 cycles. Area latency with A=255, B=255 -> 0xFE01.
- Staggered producers: producer 1 completes at t, producer 2 asserts dav_ 50 cycles later -> no CALC until producer 2 releases; rfd_in_1 stays 0 throughout; result 5*6=30.
- Consumer stall: rfd_out=0 for 30 cycles after CALC -> dav_out_ stays 1 and data_out stays at the result; then rfd_out=1 -> dav_out_=0 next edge. Holding rfd_out=1 for 10 cycles keeps dav_out_=0 with data stable.
- reset=1 for 1 cycle mid-CALC (A=7, B=9, counter 4) -> next edge: rfd_in_1=rfd_in_2=1, dav_out_=1, data_out=0. A new transaction A=3, B=4 then yields 12.
- A=0, B=200, mode=0 -> result 0. Latency 4 cycles with RECT_CALC_ZERO_SHORT_EN, 11 cycles without.

Source files
------------

// File: rtl/rect_calc_hs.sv
// rect_calc_hs: rectangle area/perimeter unit.
// Two independent dav_/rfd producers supply sides A and B. One consumer takes the 2W-bit result
// over the same handshake. Area uses a W-step LSB-first shift-add multiply.
// Optional macro RECT_CALC_ZERO_SHORT_EN: an area with a zero operand finishes after one CALC
// cycle instead of W.
module rect_calc_hs #(
  parameter int unsigned W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           mode,
  input  logic [W-1:0]   data_in_1,
  input  logic           dav_in_1_,
  output logic           rfd_in_1,
  input  logic [W-1:0]   data_in_2,
  input  logic           dav_in_2_,
  output logic           rfd_in_2,
  output logic [2*W-1:0] data_out,
  output logic           dav_out_,
  input  logic           rfd_out
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastStep = CW'(W - 1);

  typedef enum logic [1:0] {StCollect, StCalc, StWaitRfd, StHold} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           got1_q, got1_d, got2_q, got2_d;
  logic           done1_q, done1_d, done2_q, done2_d;
  logic           rfd1_q, rfd1_d, rfd2_q, rfd2_d;
  logic           mode_q, mode_d;
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] data_q, data_d;
  logic           dav_out_q, dav_out_d;

  logic [2*W-1:0] acc_sum;
  logic [W+1:0]   per_sum;
  logic [2*W-1:0] per_ext;
  logic           zero_short;

  assign rfd_in_1 = rfd1_q;
  assign rfd_in_2 = rfd2_q;
  assign data_out = data_q;
  assign dav_out_ = dav_out_q;

  // Datapath helpers: shift-add partial sum, perimeter in W+2 bits, zero-operand shortcut.
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    per_sum = ({2'b00, a_q} + {2'b00, b_q}) << 1;
    per_ext = '0;
    per_ext[W+1:0] = per_sum;
`ifdef RECT_CALC_ZERO_SHORT_EN
    zero_short = (a_q == '0) || (b_q == '0);
`else
    zero_short = 1'b0;
`endif
  end

  // Next-state logic for the FSM, the channel flags and the arithmetic registers.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    got1_d    = got1_q;
    got2_d    = got2_q;
    done1_d   = done1_q;
    done2_d   = done2_q;
    rfd1_d    = rfd1_q;
    rfd2_d    = rfd2_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dav_out_d = dav_out_q;

    unique case (state_q)
      StCollect: begin
        // Each channel captures once, then waits for its producer to drop dav_.
        if (!got1_q && !dav_in_1_) begin
          a_d    = data_in_1;
          got1_d = 1'b1;
          rfd1_d = 1'b0;
        end else if (got1_q && dav_in_1_) begin
          done1_d = 1'b1;
        end
        if (!got2_q && !dav_in_2_) begin
          b_d    = data_in_2;
          got2_d = 1'b1;
          rfd2_d = 1'b0;
        end else if (got2_q && dav_in_2_) begin
          done2_d = 1'b1;
        end
        if (done1_q && done2_q) begin
          state_d  = StCalc;
          mode_d   = mode;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{W{1'b0}}, a_q};
          mplier_d = b_q;
        end
      end
      StCalc: begin
        if (mode_q) begin
          data_d  = per_ext;
          state_d = StWaitRfd;
        end else if (zero_short) begin
          data_d  = '0;
          state_d = StWaitRfd;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            data_d  = acc_sum;
            state_d = StWaitRfd;
          end
        end
      end
      StWaitRfd: begin
        if (rfd_out) begin
          dav_out_d = 1'b0;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (!rfd_out) begin
          dav_out_d = 1'b1;
          rfd1_d    = 1'b1;
          rfd2_d    = 1'b1;
          got1_d    = 1'b0;
          got2_d    = 1'b0;
          done1_d   = 1'b0;
          done2_d   = 1'b0;
          state_d   = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StCollect;
      a_q       <= '0;
      b_q       <= '0;
      got1_q    <= 1'b0;
      got2_q    <= 1'b0;
      done1_q   <= 1'b0;
      done2_q   <= 1'b0;
      rfd1_q    <= 1'b1;
      rfd2_q    <= 1'b1;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      dav_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      got1_q    <= got1_d;
      got2_q    <= got2_d;
      done1_q   <= done1_d;
      done2_q   <= done2_d;
      rfd1_q    <= rfd1_d;
      rfd2_q    <= rfd2_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      dav_out_q <= dav_out_d;
    end
  end

endmodule

// File: tb/tb_rect_calc_hs.sv
// Testbench for rect_calc_hs (W=8): scenario tasks with a queue of expected results.
module tb_rect_calc_hs;

  localparam int unsigned W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           mode;
  logic [W-1:0]   data_in_1, data_in_2;
  logic           dav_in_1_, dav_in_2_;
  logic           rfd_in_1, rfd_in_2;
  logic [2*W-1:0] data_out;
  logic           dav_out_;
  logic           rfd_out;

  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  rect_calc_hs #(.W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .data_in_1 (data_in_1),
    .dav_in_1_ (dav_in_1_),
    .rfd_in_1  (rfd_in_1),
    .data_in_2 (data_in_2),
    .dav_in_2_ (dav_in_2_),
    .rfd_in_2  (rfd_in_2),
    .data_out  (data_out),
    .dav_out_  (dav_out_),
    .rfd_out   (rfd_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Both producers present together; dav_ released once both rfd_in have fallen.
  task automatic send_both(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                           input bit push, output bit ok);
    logic [2*W-1:0] e;
    mode      = m;
    data_in_1 = a;
    data_in_2 = b;
    dav_in_1_ = 1'b0;
    dav_in_2_ = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (!rfd_in_1 && !rfd_in_2) break;
    end
    ok = !rfd_in_1 && !rfd_in_2;
    dav_in_1_ = 1'b1;
    dav_in_2_ = 1'b1;
    if (m) e = ({8'h00, a} + {8'h00, b}) << 1;
    else   e = {8'h00, a} * {8'h00, b};
    if (push) exp_q.push_back(e);
  endtask

  // Counts clock edges until dav_out_ is low, bounded.
  task automatic wait_out(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!dav_out_) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic release_consumer();
    rfd_out = 1'b0;
    @(negedge clock);
    rfd_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (rfd_in_1 !== 1'b1 || rfd_in_2 !== 1'b1 || dav_out_ !== 1'b1 || data_out !== '0) begin
      bad++;
      $display("FAIL reset_state rfd1=%b rfd2=%b dav_out_=%b data=%h want 1 1 1 0000",
               rfd_in_1, rfd_in_2, dav_out_, data_out);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_simple(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m, input int lat);
    bit ok;
    int cyc;
    logic [2*W-1:0] e;
    rfd_out = 1'b1;
    send_both(a, b, m, 1'b1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_capture rfd1=%b rfd2=%b want 0 0", name, rfd_in_1, rfd_in_2);
    end
    wait_out(cyc, ok);
    total++;
    if (!ok || cyc != lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d (seen=%0b) want=%0d", name, cyc, ok, lat);
    end
    e = exp_q.pop_front();
    total++;
    if (data_out !== e) begin
      bad++;
      $display("FAIL %s_data got=%h want=%h", name, data_out, e);
    end
    rfd_out = 1'b0;
    @(negedge clock);
    total++;
    if (dav_out_ !== 1'b1 || rfd_in_1 !== 1'b1 || rfd_in_2 !== 1'b1) begin
      bad++;
      $display("FAIL %s_release dav_out_=%b rfd1=%b rfd2=%b want 1 1 1",
               name, dav_out_, rfd_in_1, rfd_in_2);
    end
    rfd_out = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_area();
    run_simple("area", 8'd5, 8'd6, 1'b0, 11);
  endtask

  task automatic test_perimeter();
    run_simple("perim", 8'd5, 8'd6, 1'b1, 4);
    run_simple("perim_max", 8'd255, 8'd255, 1'b1, 4);
  endtask

  task automatic test_max();
    run_simple("area_max", 8'd255, 8'd255, 1'b0, 11);
    run_simple("area_mix", 8'd173, 8'd58, 1'b0, 11);
  endtask

  task automatic test_zero();
`ifdef RECT_CALC_ZERO_SHORT_EN
    run_simple("zero", 8'd0, 8'd200, 1'b0, 4);
`else
    run_simple("zero", 8'd0, 8'd200, 1'b0, 11);
`endif
  endtask

  task automatic test_stagger();
    bit ok;
    bit quiet;
    int cyc;
    logic [2*W-1:0] e;
    rfd_out   = 1'b1;
    mode      = 1'b0;
    data_in_1 = 8'd5;
    dav_in_1_ = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (!rfd_in_1) break;
    end
    dav_in_1_ = 1'b1;
    exp_q.push_back(16'd30);
    quiet = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (rfd_in_1 !== 1'b0 || rfd_in_2 !== 1'b1 || dav_out_ !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL stagger_wait rfd1=%b rfd2=%b dav_out_=%b want 0 1 1",
               rfd_in_1, rfd_in_2, dav_out_);
    end
    data_in_2 = 8'd6;
    dav_in_2_ = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (!rfd_in_2) break;
    end
    dav_in_2_ = 1'b1;
    wait_out(cyc, ok);
    total++;
    if (!ok || cyc != 11) begin
      bad++;
      $display("FAIL stagger_latency got=%0d (seen=%0b) want=11", cyc, ok);
    end
    e = exp_q.pop_front();
    total++;
    if (data_out !== e) begin
      bad++;
      $display("FAIL stagger_data got=%h want=%h", data_out, e);
    end
    release_consumer();
    @(negedge clock);
  endtask

  task automatic test_stall();
    bit ok;
    bit steady;
    logic [2*W-1:0] e;
    rfd_out = 1'b0;
    send_both(8'd19, 8'd23, 1'b0, 1'b1, ok);
    e = exp_q[0];
    steady = 1'b1;
    repeat (30) begin
      @(negedge clock);
      if (dav_out_ !== 1'b1) steady = 1'b0;
    end
    total++;
    if (!steady) begin
      bad++;
      $display("FAIL stall_dav dav_out_ went low while rfd_out=0");
    end
    total++;
    if (data_out !== e) begin
      bad++;
      $display("FAIL stall_data got=%h want=%h", data_out, e);
    end
    rfd_out = 1'b1;
    @(negedge clock);
    total++;
    if (dav_out_ !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept dav_out_=%b want 0", dav_out_);
    end
    steady = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (dav_out_ !== 1'b0 || data_out !== e) steady = 1'b0;
    end
    total++;
    if (!steady) begin
      bad++;
      $display("FAIL stall_hold dav_out_=%b data=%h want 0 %h", dav_out_, data_out, e);
    end
    void'(exp_q.pop_front());
    release_consumer();
    @(negedge clock);
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    rfd_out = 1'b1;
    send_both(8'd7, 8'd9, 1'b0, 1'b0, ok);
    // Edge 1 sets done, edge 2 enters CALC, edges 3..6 take the counter to 4.
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (rfd_in_1 !== 1'b1 || rfd_in_2 !== 1'b1 || dav_out_ !== 1'b1 || data_out !== '0) begin
      bad++;
      $display("FAIL midcalc_reset rfd1=%b rfd2=%b dav_out_=%b data=%h want 1 1 1 0000",
               rfd_in_1, rfd_in_2, dav_out_, data_out);
    end
    @(negedge clock);
    run_simple("after_reset", 8'd3, 8'd4, 1'b0, 11);
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    data_in_1 = '0;
    data_in_2 = '0;
    dav_in_1_ = 1'b1;
    dav_in_2_ = 1'b1;
    rfd_out   = 1'b1;
    test_reset();
    test_area();
    test_perimeter();
    test_max();
    test_stagger();
    test_stall();
    test_reset_mid_calc();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
